// File: rtl/stack_frame_ctrl.sv
// Frame sequencer between the core's save/restore logic and the hardware stack:
// turns one push/pop frame request into single-word stack operations and register-file traffic.
module stack_frame_ctrl #(
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [4:0]       req_base,
  input  logic [CNT_W-1:0] req_count,
  output logic [4:0]       rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             push_enable,
  output logic             pop_enable,
  output logic [31:0]      stk_wdata,
  input  logic [31:0]      stk_rdata,
  input  logic             stack_full,
  input  logic             stack_empty,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_done
);

  typedef enum logic [1:0] {IDLE, PUSH, POP, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [4:0]       base_q, base_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_addr_q, wb_addr_d;

  logic             last_word;
  logic [4:0]       push_addr;
  logic [4:0]       pop_addr;

  assign last_word = (idx_q == count_q - CNT_W'(1));
  assign push_addr = base_q + 5'(idx_q);
  // Pops walk the frame top-down so a push followed by a pop restores each register.
  assign pop_addr  = base_q + 5'(count_q) - 5'(idx_q) - 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      error_q    <= error_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    wb_valid_d  = 1'b0;
    wb_addr_d   = wb_addr_q;
    push_enable = 1'b0;
    pop_enable  = 1'b0;
    rf_raddr    = '0;
    stk_wdata   = '0;

    // A pending pop writeback retires this cycle regardless of state.
    if (wb_valid_q) wd_d = wd_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d  = req_base;
          count_d = req_count;
          idx_d   = '0;
          wd_d    = '0;
          if (req_count == '0)                        done_d  = 1'b1;
          else if (req_count > CNT_W'(MAX_WORDS))     error_d = 1'b1;
          else                                        state_d = req_op ? POP : PUSH;
        end
      end
      PUSH: begin
        rf_raddr  = push_addr;
        stk_wdata = rf_rdata;
        if (!stack_full) begin
          push_enable = 1'b1;
          idx_d       = idx_q + CNT_W'(1);
          wd_d        = wd_q + CNT_W'(1);
          if (last_word) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      POP: begin
        if (!stack_empty) begin
          pop_enable = 1'b1;
          wb_valid_d = 1'b1;
          wb_addr_d  = pop_addr;
          idx_d      = idx_q + CNT_W'(1);
          if (last_word) state_d = DRAIN;
        end else begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rf_we      = wb_valid_q;
  assign rf_waddr   = wb_valid_q ? wb_addr_q : 5'd0;
  assign rf_wdata   = wb_valid_q ? stk_rdata : 32'd0;
  assign done       = done_q;
  assign error      = error_q;
  assign words_done = wd_q;

endmodule
